// File: rtl/matrix_led_pkg.sv
// Shared defaults and state type for the LED matrix frame buffer.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package matrix_led_pkg;

  localparam int DEFAULT_ROW_COUNT = 8;
  localparam int DEFAULT_COL_COUNT = 8;

  // IDLE accepts writes and commits; PENDING waits for the scanner to wrap;
  // COPY re-seeds the new back bank from the freshly published front bank.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COPY    = 2'd2
  } fb_state_t;

endpackage

// File: rtl/matrix_fb_bank.sv
// One frame bank: ROW_COUNT x COL_COUNT registers, one write port, one-hot scan read, binary copy read.
// Latency: write lands at the clock edge, both reads are combinational.
// Backpressure: none; the write port is unconditionally accepted when wr_en is high.
module matrix_fb_bank
  import matrix_led_pkg::*;
#(
  parameter int ROW_COUNT = DEFAULT_ROW_COUNT,
  parameter int COL_COUNT = DEFAULT_COL_COUNT,
  parameter int ROW_W     = $clog2(DEFAULT_ROW_COUNT)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [ROW_W-1:0]     wr_row,
  input  logic [COL_COUNT-1:0] wr_data,
  input  logic [ROW_COUNT-1:0] rd_row,
  output logic [COL_COUNT-1:0] rd_data,
  input  logic [ROW_W-1:0]     cp_row,
  output logic [COL_COUNT-1:0] cp_data
);

  localparam logic [ROW_COUNT-1:0] ROW_ONE = ROW_COUNT'(1);

  logic [COL_COUNT-1:0] mem [ROW_COUNT];
  logic [COL_COUNT-1:0] rd_or;
  logic                 rd_onehot;

  // Row storage; reset clears the whole frame immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROW_COUNT; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  // Scanner read: OR of selected rows, blanked unless exactly one row is selected.
  always_comb begin
    rd_or = '0;
    for (int i = 0; i < ROW_COUNT; i++) begin
      if (rd_row[i]) begin
        rd_or = rd_or | mem[i];
      end
    end
    rd_onehot = (rd_row != '0) && ((rd_row & (rd_row - ROW_ONE)) == '0);
    rd_data   = rd_onehot ? rd_or : '0;
  end

  assign cp_data = mem[cp_row];

endmodule

// File: rtl/matrix_frame_buffer.sv
// LED matrix frame buffer; double buffering with scanner-synchronised swap when MATRIX_FB_DOUBLE_BUFFER_EN is defined.
// Latency: double-buffered, commit is visible one frame_start plus one cycle later; single bank, writes visible next cycle.
// Backpressure: double-buffered, wr_ready/commit_ready low from commit until ROW_COUNT cycles after the swap; otherwise never.
module matrix_frame_buffer
  import matrix_led_pkg::*;
#(
  parameter int ROW_COUNT = DEFAULT_ROW_COUNT,
  parameter int COL_COUNT = DEFAULT_COL_COUNT
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [$clog2(ROW_COUNT)-1:0] wr_row,
  input  logic [COL_COUNT-1:0]         wr_data,
  input  logic                         commit_valid,
  output logic                         commit_ready,
  output logic                         commit_done,
  input  logic                         frame_start,
  input  logic [ROW_COUNT-1:0]         rd_row,
  output logic [COL_COUNT-1:0]         rd_data
);

  localparam int               ROW_W     = $clog2(ROW_COUNT);
  localparam logic [ROW_W:0]   ROW_LIMIT = (ROW_W + 1)'(ROW_COUNT);

  // Writes to rows beyond the matrix complete the handshake but store nothing.
  logic wr_in_range;
  assign wr_in_range = ({1'b0, wr_row} < ROW_LIMIT);

`ifdef MATRIX_FB_DOUBLE_BUFFER_EN

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROW_COUNT - 1);
  localparam logic [ROW_W-1:0] ROW_STEP = ROW_W'(1);

  fb_state_t            state_q, state_d;
  logic                 front_sel_q, front_sel_d;
  logic [ROW_W-1:0]     copy_cnt_q, copy_cnt_d;
  logic                 commit_done_q;
  logic [1:0]           bank_wr_en;
  logic [ROW_W-1:0]     bank_wr_row  [2];
  logic [COL_COUNT-1:0] bank_wr_data [2];
  logic [COL_COUNT-1:0] bank_rd_data [2];
  logic [COL_COUNT-1:0] bank_cp_data [2];

  // State, displayed-bank pointer, copy counter and the swap-done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      front_sel_q   <= 1'b0;
      copy_cnt_q    <= '0;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      front_sel_q   <= front_sel_d;
      copy_cnt_q    <= copy_cnt_d;
      commit_done_q <= (state_q == PENDING) && frame_start;
    end
  end

  // Next state, handshakes and routing of the single write port of each bank.
  always_comb begin
    state_d         = state_q;
    front_sel_d     = front_sel_q;
    copy_cnt_d      = copy_cnt_q;
    wr_ready        = 1'b0;
    commit_ready    = 1'b0;
    bank_wr_en      = '0;
    bank_wr_row[0]  = wr_row;
    bank_wr_row[1]  = wr_row;
    bank_wr_data[0] = wr_data;
    bank_wr_data[1] = wr_data;
    case (state_q)
      IDLE: begin
        wr_ready     = 1'b1;
        commit_ready = 1'b1;
        if (wr_valid && wr_in_range) begin
          bank_wr_en[~front_sel_q] = 1'b1;
        end
        // A write in the commit cycle is already in the back bank, so it is part of the frame.
        if (commit_valid) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (frame_start) begin
          front_sel_d = ~front_sel_q;
          copy_cnt_d  = '0;
          state_d     = COPY;
        end
      end
      COPY: begin
        // Re-seed the back bank so the next frame starts from what is on screen.
        bank_wr_en[~front_sel_q]   = 1'b1;
        bank_wr_row[~front_sel_q]  = copy_cnt_q;
        bank_wr_data[~front_sel_q] = bank_cp_data[front_sel_q];
        if (copy_cnt_q == LAST_ROW) begin
          copy_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          copy_cnt_d = copy_cnt_q + ROW_STEP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    matrix_fb_bank #(
      .ROW_COUNT (ROW_COUNT),
      .COL_COUNT (COL_COUNT),
      .ROW_W     (ROW_W)
    ) u_bank (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_en   (bank_wr_en[b]),
      .wr_row  (bank_wr_row[b]),
      .wr_data (bank_wr_data[b]),
      .rd_row  (rd_row),
      .rd_data (bank_rd_data[b]),
      .cp_row  (copy_cnt_q),
      .cp_data (bank_cp_data[b])
    );
  end

  assign rd_data     = bank_rd_data[front_sel_q];
  assign commit_done = commit_done_q;

`else

  logic                 commit_done_q;
  logic [COL_COUNT-1:0] unused_cp_data;
  logic                 unused_frame_start;

  assign wr_ready           = 1'b1;
  assign commit_ready       = 1'b1;
  assign unused_frame_start = frame_start;

  // With a single bank every commit completes on the following cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      commit_done_q <= 1'b0;
    end else begin
      commit_done_q <= commit_valid;
    end
  end

  matrix_fb_bank #(
    .ROW_COUNT (ROW_COUNT),
    .COL_COUNT (COL_COUNT),
    .ROW_W     (ROW_W)
  ) u_bank (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (wr_valid && wr_in_range),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .rd_row  (rd_row),
    .rd_data (rd_data),
    .cp_row  ('0),
    .cp_data (unused_cp_data)
  );

  assign commit_done = commit_done_q;

`endif

endmodule

// File: doc/matrix_frame_buffer.md
MATRIX_FRAME_BUFFER -- requirements
Module: matrix_frame_buffer

Interface
REQ-001 SHALL have parameter ROW_COUNT, default 8, number of matrix rows.
REQ-002 SHALL have parameter COL_COUNT, default 8, number of columns (bits per row).
REQ-003 SHALL have port clock  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_valid  input  1  row write request.
REQ-006 SHALL have port wr_ready  output  1  row write can be accepted.
REQ-007 SHALL have port wr_row  input  $clog2(ROW_COUNT)  binary row index of the write.
REQ-008 SHALL have port wr_data  input  COL_COUNT  column pattern of the write.
REQ-009 SHALL have port commit_valid  input  1  request to publish the back buffer.
REQ-010 SHALL have port commit_ready  output  1  commit can be accepted.
REQ-011 SHALL have port commit_done  output  1  one-cycle pulse when the committed frame becomes visible.
REQ-012 SHALL have port frame_start  input  1  one-cycle pulse from the downstream scanner when the scan returns to row 0.
REQ-013 SHALL have port rd_row  input  ROW_COUNT  one-hot row select from the scanner.
REQ-014 SHALL have port rd_data  output  COL_COUNT  pattern of the selected front-buffer row.

Function
REQ-015 SHALL hold two banks (front, back); front_sel names the displayed bank.
REQ-016 SHALL drive rd_data combinationally from the front bank; an rd_row that is zero or not one-hot SHALL give rd_data = 0.
REQ-017 SHALL accept a write when wr_valid && wr_ready and SHALL store wr_data into the back bank row wr_row at that clock edge.
REQ-018 SHALL ignore a write whose wr_row >= ROW_COUNT, while still completing the handshake.
REQ-019 SHALL use the states IDLE, PENDING and COPY.
REQ-020 SHALL assert wr_ready and commit_ready only in IDLE.
REQ-021 SHALL accept a commit in IDLE when commit_valid is high and SHALL then go to PENDING.
REQ-022 SHALL include in the commit a write accepted in the same cycle as that commit.
REQ-023 SHALL ignore a frame_start that coincides with commit acceptance, so the swap waits for the next frame_start.
REQ-024 SHALL, on frame_start in PENDING, toggle front_sel, pulse commit_done in the next cycle, and go to COPY.
REQ-025 SHALL, in COPY, copy one row per cycle from the new front bank to the new back bank, rows 0 to ROW_COUNT-1, taking ROW_COUNT cycles, and then return to IDLE.
REQ-026 SHALL ignore frame_start in IDLE and COPY.
REQ-027 SHALL make latency from commit acceptance to visible data one frame_start plus one cycle; the next write SHALL be accepted no earlier than ROW_COUNT cycles after the swap.

Reset
REQ-028 SHALL, on reset_n low, immediately clear both banks to 0, set front_sel = 0, state = IDLE, and the copy counter to 0.
REQ-029 SHALL drive reset values wr_ready = 1, commit_ready = 1, commit_done = 0, and rd_data = 0.
REQ-030 SHALL drop a pending or copying commit when reset is asserted mid-operation, with no commit_done pulse.

Configuration
REQ-031 SHALL use the macro MATRIX_FB_DOUBLE_BUFFER_EN; when it is defined, behaviour SHALL be REQ-015..REQ-027.
REQ-032 SHALL, when MATRIX_FB_DOUBLE_BUFFER_EN is undefined, use one bank only, with writes visible on rd_data the cycle after acceptance.
REQ-033 SHALL, when MATRIX_FB_DOUBLE_BUFFER_EN is undefined, hold wr_ready and commit_ready at 1, pulse commit_done the cycle after each accepted commit, ignore frame_start, and have no PENDING or COPY state.

Structure
REQ-034 SHALL place the ROW_COUNT and COL_COUNT defaults and the enum fb_state_t {IDLE, PENDING, COPY} in the shared package matrix_led_pkg.
REQ-035 SHALL implement each bank as sub-module matrix_fb_bank: a ROW_COUNT x COL_COUNT register array with one synchronous write port and a one-hot combinational read mux; it SHALL be instantiated twice, or once without the macro.

Verification
REQ-036 SHALL cover: after reset, rd_row = 8'b0000_0001 -> rd_data = 8'h00; wr_ready = 1; commit_ready = 1.
REQ-037 SHALL cover: write row 3 = 8'h18, commit, frame_start -> rd_row = 8'b0000_1000 gives 8'h00 before the swap, gives 8'h18 from the cycle of the commit_done pulse, and commit_done is exactly 1 cycle wide.
REQ-038 SHALL cover: write row 0 = 8'h81, commit, then after the swap and 8 COPY cycles write row 7 = 8'h81, commit, frame_start -> rows 0 and 7 both read 8'h81.
REQ-039 SHALL cover: commit and frame_start in the same cycle -> no swap; the swap happens at the next frame_start, and wr_ready stays 0 from acceptance until 8 cycles after the swap.
REQ-040 SHALL cover: reset_n pulsed low while in PENDING -> no commit_done, all rows read 8'h00, state is IDLE.
REQ-041 SHALL cover: without the macro, write row 5 = 8'h24 -> rd_row = 8'b0010_0000 reads 8'h24 one cycle later; rd_row = 8'b0000_0011 reads 8'h00.
